reg_file_rw: RTL
================

// Module: reg_file_rw
// PURPOSE
//  - Integer register file at the consuming end of the MEM/WB write-back path.
//  - Commits the write-back (flag, address, data) triple from the MEM/WB latch, and serves two registered read ports to the ID stage.
//  - x0 is hardwired to zero. Read outputs are frozen while ID is stalled.
// PARAMETERS
//  DATA_W    32  register/data width (matches Data_size)
//  ADDR_W    5   register index width (matches Data_Address_size)
//  NREG      32  number of architectural registers (2**ADDR_W)
//  STALL_W   6   stall bus width (matches Stall_size)
//  ID_STALL  1   stall_state bit that freezes the ID-side read outputs
// PORTS
//  clk            in   1        clock, all state on posedge
//  rst            in   1        synchronous reset, ACTIVE-LOW (0 = reset)
//  stall_state    in   STALL_W  stall bus; bit ID_STALL holds read outputs
//  modify_flag    in   1        write enable from MEM/WB latch
//  modify_address in   ADDR_W   write index
//  modify_data    in   DATA_W   write data
//  read1_flag     in   1        port 1 read request from ID
//  read1_address  in   ADDR_W   port 1 index
//  read2_flag     in   1        port 2 read request from ID
//  read2_address  in   ADDR_W   port 2 index
//  read1_data     out  DATA_W   port 1 registered operand
//  read2_data     out  DATA_W   port 2 registered operand
// BEHAVIOUR
//  - Reset: rst==0 at posedge clears all NREG entries, read1_data, read2_data, and the internal held indices/flags to 0.
//  - Reset takes priority over write, read and stall in the same cycle.
//  - Write: at posedge, when rst==1 and modify_flag==1 and modify_address!=0, then regs[modify_address] <= modify_data.
//    - Writes to x0 are dropped.
//    - Writes are never blocked by stall_state; WB is downstream of every stall.
//  - Read latency is 1 cycle. At a posedge with rst==1 and stall_state[ID_STALL]==0, each port N:
//    - Latches readN_address and readN_flag into held_addrN and held_flagN.
//    - Sets readN_data <= readN_flag ? src(readN_address) : 0.
//    - src(0) is always 0, regardless of any write to x0.
//  - Stall: while stall_state[ID_STALL]==1, readN_data, held_addrN and held_flagN keep their values.
//    - Exception: the bypass refresh defined under CONFIGURATION.
//  - Both ports may read the same index in the same cycle; both return the same value.
//  - A write and two reads may target the same index in one cycle. The result is defined by the bypass rule for each port independently.
//  - All other stall_state bits are ignored.
//  - No arithmetic. Data passes through unmodified at full DATA_W width.
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined:
//   - src(a) = (modify_flag && modify_address==a && a!=0) ? modify_data : regs[a], i.e. write-through.
//   - The same-cycle WB value reaches ID one cycle later.
//   - Stall refresh: while stalled, if held_flagN==1, modify_flag==1 and modify_address==held_addrN!=0, then readN_data <= modify_data.
//   - Prevents a stale held operand.
//  REG_FILE_BYPASS_EN undefined:
//   - src(a) = regs[a], i.e. read-before-write.
//   - A same-cycle write is visible only to reads issued on the following cycle or later.
//   - No stall refresh; held outputs are fully frozen.
//   - The hazard unit must cover the extra WB->ID cycle.
// TESTING
//  1. Hold rst=0 for 2 cycles, then release. Read x5 and x31 -> both ports return 0 one cycle after the request.
//  2. Write x3=0xDEADBEEF. Next cycle read1 x3 and read2 x0 -> read1_data=0xDEADBEEF, read2_data=0.
//  3. Write x0=0x12345678, then read x0 on both ports -> 0 on both.
//  4. Same cycle: write x7=0xA5A5A5A5 and read1 x7 (x7 previously 0x11).
//     - BYPASS_EN: read1_data=0xA5A5A5A5.
//     - Without BYPASS_EN: read1_data=0x11, then 0xA5A5A5A5 when the read is reissued.
//  5. read1 x4 (=0x4), then assert stall_state[1] for 3 cycles while changing read1_address to 9 and writing x4=0x44 in stall cycle 2.
//     - BYPASS_EN: read1_data becomes 0x44 after the write; otherwise it holds 0x4 throughout.
//     - After release, read1_data = value of x9.
//  6. Assert rst=0 mid-stall, with modify_flag=1 writing x2=0xFF.
//     - All outputs become 0 and x2 reads 0 after release; reset wins over the write.

Source files
------------

// File: rtl/reg_file_rw.sv
// Integer register file fed by the MEM/WB write-back, with two registered ID read ports.
// Optional write-through bypass and stall refresh are enabled by defining REG_FILE_BYPASS_EN.
module reg_file_rw #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREG     = 32,
  parameter int STALL_W  = 6,
  parameter int ID_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall_state,
  input  logic              modify_flag,
  input  logic [ADDR_W-1:0] modify_address,
  input  logic [DATA_W-1:0] modify_data,
  input  logic              read1_flag,
  input  logic [ADDR_W-1:0] read1_address,
  input  logic              read2_flag,
  input  logic [ADDR_W-1:0] read2_address,
  output logic [DATA_W-1:0] read1_data,
  output logic [DATA_W-1:0] read2_data
);

  logic [DATA_W-1:0] regs_r [NREG];
  logic [ADDR_W-1:0] held_addr1_r;
  logic [ADDR_W-1:0] held_addr2_r;
  logic              held_flag1_r;
  logic              held_flag2_r;
  logic [DATA_W-1:0] src1_s;
  logic [DATA_W-1:0] src2_s;
  logic              wr_en_s;
  logic              refresh1_s;
  logic              refresh2_s;
  logic              unused_s;

  // Held indices are only consumed by the bypass refresh; other stall bits are don't-care.
  assign unused_s = ^{stall_state, held_addr1_r, held_addr2_r, held_flag1_r, held_flag2_r};

  assign wr_en_s = modify_flag && (modify_address != {ADDR_W{1'b0}});

  // Read source selection for both ports, with x0 forced to zero.
  always_comb begin
    src1_s     = {DATA_W{1'b0}};
    src2_s     = {DATA_W{1'b0}};
    refresh1_s = 1'b0;
    refresh2_s = 1'b0;
    if (read1_address == {ADDR_W{1'b0}}) begin
      src1_s = {DATA_W{1'b0}};
`ifdef REG_FILE_BYPASS_EN
    end else if (wr_en_s && (modify_address == read1_address)) begin
      src1_s = modify_data;
`endif
    end else begin
      src1_s = regs_r[read1_address];
    end
    if (read2_address == {ADDR_W{1'b0}}) begin
      src2_s = {DATA_W{1'b0}};
`ifdef REG_FILE_BYPASS_EN
    end else if (wr_en_s && (modify_address == read2_address)) begin
      src2_s = modify_data;
`endif
    end else begin
      src2_s = regs_r[read2_address];
    end
`ifdef REG_FILE_BYPASS_EN
    // A write landing on a held operand during a stall must not leave it stale.
    refresh1_s = held_flag1_r && wr_en_s && (modify_address == held_addr1_r);
    refresh2_s = held_flag2_r && wr_en_s && (modify_address == held_addr2_r);
`else
    refresh1_s = 1'b0;
    refresh2_s = 1'b0;
`endif
  end

  // Register array, held read state and registered operands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      held_addr1_r <= {ADDR_W{1'b0}};
      held_addr2_r <= {ADDR_W{1'b0}};
      held_flag1_r <= 1'b0;
      held_flag2_r <= 1'b0;
      read1_data   <= {DATA_W{1'b0}};
      read2_data   <= {DATA_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        regs_r[modify_address] <= modify_data;
      end else begin
        regs_r[modify_address] <= regs_r[modify_address];
      end
      if (!stall_state[ID_STALL]) begin
        held_addr1_r <= read1_address;
        held_addr2_r <= read2_address;
        held_flag1_r <= read1_flag;
        held_flag2_r <= read2_flag;
        read1_data   <= read1_flag ? src1_s : {DATA_W{1'b0}};
        read2_data   <= read2_flag ? src2_s : {DATA_W{1'b0}};
      end else begin
        if (refresh1_s) begin
          read1_data <= modify_data;
        end else begin
          read1_data <= read1_data;
        end
        if (refresh2_s) begin
          read2_data <= modify_data;
        end else begin
          read2_data <= read2_data;
        end
      end
    end
  end

endmodule
